// File: rtl/axi_default_slave_pkg.sv
// Shared definitions for the AXI default slave.
//   - Default bus widths used when the top is instantiated without overrides.
//   - AXI response encodings.
//   - State encodings for the independent write and read engines.
package axi_default_slave_pkg;

  localparam int unsigned AXI_ID_BITS   = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage : axi_default_slave_pkg

// File: rtl/axi_burst_counter.sv
// Beat counter for one AXI burst.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   clear_i : restart the count at zero (address handshake)
//   incr_i  : one data beat was transferred
//   len_i   : latched burst length (beats - 1)
//   last_o  : the current beat is the final one (count == len)
module axi_burst_counter #(
  parameter int unsigned LEN_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                incr_i,
  input  logic [LEN_BITS-1:0] len_i,
  output logic                last_o
);

  logic [LEN_BITS-1:0] count_q;
  logic [LEN_BITS-1:0] count_d;

  assign last_o = (count_q == len_i);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && !last_o) begin
      // Holding at the final beat keeps a maximum-length burst from wrapping.
      count_d = count_q + LEN_BITS'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : axi_burst_counter

// File: rtl/axi_default_slave.sv
// AXI default slave: terminates every write and read burst routed to an
// unmapped address with a DECERR response. Write and read engines are
// independent, one outstanding transaction each; data is never stored.
//   ACLK / ARESETn       : clock, synchronous active-low reset
//   AW*_S / W*_S / B*_S  : write address, data and response channels
//   AR*_S / R*_S         : read address and data channels (RDATA always 0)
//   proto_err_o          : sticky, set when WLAST disagrees with the burst length
module axi_default_slave
  import axi_default_slave_pkg::*;
#(
  parameter int unsigned ID_BITS   = AXI_ID_BITS,
  parameter int unsigned ADDR_BITS = AXI_ADDR_BITS,
  parameter int unsigned DATA_BITS = AXI_DATA_BITS,
  parameter int unsigned LEN_BITS  = AXI_LEN_BITS
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  // Write address
  input  logic [ID_BITS-1:0]   AWID_S,
  input  logic [ADDR_BITS-1:0] AWADDR_S,
  input  logic [LEN_BITS-1:0]  AWLEN_S,
  input  logic                 AWVALID_S,
  output logic                 AWREADY_S,
  // Write data
  input  logic [DATA_BITS-1:0] WDATA_S,
  input  logic                 WLAST_S,
  input  logic                 WVALID_S,
  output logic                 WREADY_S,
  // Write response
  output logic [ID_BITS-1:0]   BID_S,
  output logic [1:0]           BRESP_S,
  output logic                 BVALID_S,
  input  logic                 BREADY_S,
  // Read address
  input  logic [ID_BITS-1:0]   ARID_S,
  input  logic [ADDR_BITS-1:0] ARADDR_S,
  input  logic [LEN_BITS-1:0]  ARLEN_S,
  input  logic                 ARVALID_S,
  output logic                 ARREADY_S,
  // Read data
  output logic [ID_BITS-1:0]   RID_S,
  output logic [DATA_BITS-1:0] RDATA_S,
  output logic [1:0]           RRESP_S,
  output logic                 RLAST_S,
  output logic                 RVALID_S,
  input  logic                 RREADY_S,
  // Status
  output logic                 proto_err_o
);

  // Address and data payloads are irrelevant to an error responder.
  logic unused_payload;
  assign unused_payload = ^{AWADDR_S, WDATA_S, ARADDR_S};

  // Keeps both address READYs low while in reset and for the reset cycle
  // itself; they rise after the first clock edge with ARESETn high.
  logic ready_en_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  wr_state_e           w_state_q, w_state_d;
  logic [ID_BITS-1:0]  w_id_q, w_id_d;
  logic [LEN_BITS-1:0] w_len_q, w_len_d;
  logic                proto_err_q, proto_err_d;
  logic                aw_hs, w_hs, w_last;

  assign aw_hs = AWVALID_S && ready_en_q && (w_state_q == W_IDLE);
  assign w_hs  = WVALID_S && (w_state_q == W_DATA);

  axi_burst_counter #(.LEN_BITS(LEN_BITS)) u_w_counter (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .clear_i(aw_hs),
    .incr_i (w_hs),
    .len_i  (w_len_q),
    .last_o (w_last)
  );

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_len_d     = w_len_q;
    proto_err_d = proto_err_q;
    AWREADY_S   = 1'b0;
    WREADY_S    = 1'b0;
    BVALID_S    = 1'b0;
    BID_S       = '0;
    BRESP_S     = RESP_OKAY;

    unique case (w_state_q)
      W_IDLE: begin
        AWREADY_S = ready_en_q;
        if (aw_hs) begin
          w_id_d    = AWID_S;
          w_len_d   = AWLEN_S;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WREADY_S = 1'b1;
        if (w_hs) begin
          // Termination always follows the beat count; WLAST only flags errors.
          if (WLAST_S != w_last) begin
            proto_err_d = 1'b1;
          end
          if (w_last) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        BVALID_S = 1'b1;
        BRESP_S  = RESP_DECERR;
        BID_S    = w_id_q;
        if (BREADY_S) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_len_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_len_q     <= w_len_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err_o = proto_err_q;

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  rd_state_e           r_state_q, r_state_d;
  logic [ID_BITS-1:0]  r_id_q, r_id_d;
  logic [LEN_BITS-1:0] r_len_q, r_len_d;
  logic                ar_hs, r_hs, r_last;

  assign ar_hs = ARVALID_S && ready_en_q && (r_state_q == R_IDLE);
  assign r_hs  = RREADY_S && (r_state_q == R_DATA);

  axi_burst_counter #(.LEN_BITS(LEN_BITS)) u_r_counter (
    .clk_i  (ACLK),
    .rst_ni (ARESETn),
    .clear_i(ar_hs),
    .incr_i (r_hs),
    .len_i  (r_len_q),
    .last_o (r_last)
  );

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    ARREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    RID_S     = '0;
    RDATA_S   = '0;
    RRESP_S   = RESP_OKAY;
    RLAST_S   = 1'b0;

    unique case (r_state_q)
      R_IDLE: begin
        ARREADY_S = ready_en_q;
        if (ar_hs) begin
          r_id_d    = ARID_S;
          r_len_d   = ARLEN_S;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // Payload depends only on registered state, so it is stable under stall.
        RVALID_S = 1'b1;
        RRESP_S  = RESP_DECERR;
        RID_S    = r_id_q;
        RLAST_S  = r_last;
        if (r_hs && r_last) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
    end
  end

endmodule : axi_default_slave

// File: tb/tb_axi_default_slave.sv
// Directed self-checking bench for axi_default_slave. Inputs are driven 1 ns
// after each rising edge, and outputs are sampled at the same point.
module tb_axi_default_slave;

  localparam int ID_BITS   = 8;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int LEN_BITS  = 4;

  logic                 ACLK = 1'b0;
  logic                 ARESETn;
  logic [ID_BITS-1:0]   AWID_S;
  logic [ADDR_BITS-1:0] AWADDR_S;
  logic [LEN_BITS-1:0]  AWLEN_S;
  logic                 AWVALID_S;
  logic                 AWREADY_S;
  logic [DATA_BITS-1:0] WDATA_S;
  logic                 WLAST_S;
  logic                 WVALID_S;
  logic                 WREADY_S;
  logic [ID_BITS-1:0]   BID_S;
  logic [1:0]           BRESP_S;
  logic                 BVALID_S;
  logic                 BREADY_S;
  logic [ID_BITS-1:0]   ARID_S;
  logic [ADDR_BITS-1:0] ARADDR_S;
  logic [LEN_BITS-1:0]  ARLEN_S;
  logic                 ARVALID_S;
  logic                 ARREADY_S;
  logic [ID_BITS-1:0]   RID_S;
  logic [DATA_BITS-1:0] RDATA_S;
  logic [1:0]           RRESP_S;
  logic                 RLAST_S;
  logic                 RVALID_S;
  logic                 RREADY_S;
  logic                 proto_err_o;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_default_slave #(
    .ID_BITS  (ID_BITS),
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS),
    .LEN_BITS (LEN_BITS)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .AWID_S     (AWID_S),
    .AWADDR_S   (AWADDR_S),
    .AWLEN_S    (AWLEN_S),
    .AWVALID_S  (AWVALID_S),
    .AWREADY_S  (AWREADY_S),
    .WDATA_S    (WDATA_S),
    .WLAST_S    (WLAST_S),
    .WVALID_S   (WVALID_S),
    .WREADY_S   (WREADY_S),
    .BID_S      (BID_S),
    .BRESP_S    (BRESP_S),
    .BVALID_S   (BVALID_S),
    .BREADY_S   (BREADY_S),
    .ARID_S     (ARID_S),
    .ARADDR_S   (ARADDR_S),
    .ARLEN_S    (ARLEN_S),
    .ARVALID_S  (ARVALID_S),
    .ARREADY_S  (ARREADY_S),
    .RID_S      (RID_S),
    .RDATA_S    (RDATA_S),
    .RRESP_S    (RRESP_S),
    .RLAST_S    (RLAST_S),
    .RVALID_S   (RVALID_S),
    .RREADY_S   (RREADY_S),
    .proto_err_o(proto_err_o)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    tick();
    tick();
    checks++;
    if ({AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S, proto_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 000000",
               {AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S, proto_err_o});
    end
    checks++;
    if ({BID_S, RID_S, RLAST_S, RRESP_S, BRESP_S} !== 21'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h, expected 0", {BID_S, RID_S, RLAST_S, RRESP_S, BRESP_S});
    end
    ARESETn = 1'b1;
    tick();
    checks++;
    if ({AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S} !== 5'b11000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b, expected 11000",
               {AWREADY_S, ARREADY_S, WREADY_S, BVALID_S, RVALID_S});
    end
  endtask

  task automatic test_single_write();
    // W beat presented together with AW must not be taken before AW.
    AWVALID_S = 1'b1; AWID_S = 8'h5A; AWLEN_S = 4'd0; AWADDR_S = 32'hDEAD_0000;
    WVALID_S = 1'b1; WLAST_S = 1'b1; WDATA_S = 32'h1234_5678; BREADY_S = 1'b1;
    checks++;
    if (WREADY_S !== 1'b0) begin
      errors++;
      $display("FAIL w_before_aw: got WREADY=%b, expected 0", WREADY_S);
    end
    tick();
    AWVALID_S = 1'b0;
    checks++;
    if ({AWREADY_S, WREADY_S, BVALID_S} !== 3'b010) begin
      errors++;
      $display("FAIL wr1_data_phase: got %b, expected 010", {AWREADY_S, WREADY_S, BVALID_S});
    end
    tick();
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    checks++;
    if ({BVALID_S, BID_S, BRESP_S, WREADY_S, proto_err_o} !== {1'b1, 8'h5A, 2'b11, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr1_resp: got %h, expected %h",
               {BVALID_S, BID_S, BRESP_S, WREADY_S, proto_err_o}, {1'b1, 8'h5A, 2'b11, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({BVALID_S, AWREADY_S} !== 2'b01) begin
      errors++;
      $display("FAIL wr1_done: got %b, expected 01", {BVALID_S, AWREADY_S});
    end
  endtask

  task automatic test_read_stall();
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int rbeat = 0;
    ARVALID_S = 1'b1; ARID_S = 8'h21; ARLEN_S = 4'd3; ARADDR_S = 32'hBAD0_0040;
    tick();
    ARVALID_S = 1'b0;
    for (int i = 0; i < 6; i++) begin
      RREADY_S = pat[i];
      checks++;
      if ({RVALID_S, RID_S, RRESP_S, RLAST_S, ARREADY_S} !== {1'b1, 8'h21, 2'b11, (rbeat == 3), 1'b0}) begin
        errors++;
        $display("FAIL rd4_cycle%0d: got %h, expected %h", i,
                 {RVALID_S, RID_S, RRESP_S, RLAST_S, ARREADY_S},
                 {1'b1, 8'h21, 2'b11, (rbeat == 3), 1'b0});
      end
      checks++;
      if (RDATA_S !== 32'h0) begin
        errors++;
        $display("FAIL rd4_rdata%0d: got %h, expected 0", i, RDATA_S);
      end
      if (pat[i]) rbeat++;
      tick();
    end
    RREADY_S = 1'b0;
    checks++;
    if ({RVALID_S, ARREADY_S, RLAST_S, RRESP_S} !== 5'b01000) begin
      errors++;
      $display("FAIL rd4_done: got %b, expected 01000", {RVALID_S, ARREADY_S, RLAST_S, RRESP_S});
    end
  endtask

  task automatic test_wlast_mismatch();
    AWVALID_S = 1'b1; AWID_S = 8'h33; AWLEN_S = 4'd2; BREADY_S = 1'b0;
    tick();
    AWVALID_S = 1'b0;
    WVALID_S = 1'b1; WLAST_S = 1'b1;          // early WLAST on the first beat
    checks++;
    if ({WREADY_S, proto_err_o} !== 2'b10) begin
      errors++;
      $display("FAIL mis_before: got %b, expected 10", {WREADY_S, proto_err_o});
    end
    tick();
    WLAST_S = 1'b0;
    checks++;
    if ({WREADY_S, BVALID_S, proto_err_o} !== 3'b101) begin
      errors++;
      $display("FAIL mis_beat1: got %b, expected 101", {WREADY_S, BVALID_S, proto_err_o});
    end
    tick();
    WLAST_S = 1'b1;
    checks++;
    if ({WREADY_S, BVALID_S, proto_err_o} !== 3'b101) begin
      errors++;
      $display("FAIL mis_beat2: got %b, expected 101", {WREADY_S, BVALID_S, proto_err_o});
    end
    tick();
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    checks++;
    if ({BVALID_S, BID_S, BRESP_S, WREADY_S, proto_err_o} !== {1'b1, 8'h33, 2'b11, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mis_resp: got %h, expected %h",
               {BVALID_S, BID_S, BRESP_S, WREADY_S, proto_err_o}, {1'b1, 8'h33, 2'b11, 1'b0, 1'b1});
    end
    BREADY_S = 1'b1;
    tick();
    checks++;
    if ({BVALID_S, AWREADY_S, proto_err_o} !== 3'b011) begin
      errors++;
      $display("FAIL mis_sticky: got %b, expected 011", {BVALID_S, AWREADY_S, proto_err_o});
    end
  endtask

  task automatic test_concurrent();
    AWVALID_S = 1'b1; AWID_S = 8'h01; AWLEN_S = 4'd1;
    ARVALID_S = 1'b1; ARID_S = 8'h02; ARLEN_S = 4'd15;
    BREADY_S = 1'b1; RREADY_S = 1'b1;
    checks++;
    if ({AWREADY_S, ARREADY_S} !== 2'b11) begin
      errors++;
      $display("FAIL conc_ready: got %b, expected 11", {AWREADY_S, ARREADY_S});
    end
    tick();
    AWVALID_S = 1'b0; ARVALID_S = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      WVALID_S = (k < 2);
      WLAST_S  = (k == 1);
      if (k < 16) begin
        checks++;
        if ({RVALID_S, RID_S, RLAST_S, ARREADY_S} !== {1'b1, 8'h02, (k == 15), 1'b0}) begin
          errors++;
          $display("FAIL conc_r%0d: got %h, expected %h", k,
                   {RVALID_S, RID_S, RLAST_S, ARREADY_S}, {1'b1, 8'h02, (k == 15), 1'b0});
        end
      end else begin
        checks++;
        if ({RVALID_S, ARREADY_S, RID_S} !== {1'b0, 1'b1, 8'h00}) begin
          errors++;
          $display("FAIL conc_r_done: got %h, expected %h",
                   {RVALID_S, ARREADY_S, RID_S}, {1'b0, 1'b1, 8'h00});
        end
      end
      if (k < 2) begin
        checks++;
        if ({WREADY_S, BVALID_S} !== 2'b10) begin
          errors++;
          $display("FAIL conc_w%0d: got %b, expected 10", k, {WREADY_S, BVALID_S});
        end
      end else if (k == 2) begin
        checks++;
        if ({BVALID_S, BID_S, BRESP_S, WREADY_S} !== {1'b1, 8'h01, 2'b11, 1'b0}) begin
          errors++;
          $display("FAIL conc_b: got %h, expected %h",
                   {BVALID_S, BID_S, BRESP_S, WREADY_S}, {1'b1, 8'h01, 2'b11, 1'b0});
        end
      end else begin
        checks++;
        if ({BVALID_S, AWREADY_S, WREADY_S} !== 3'b010) begin
          errors++;
          $display("FAIL conc_w_idle%0d: got %b, expected 010", k, {BVALID_S, AWREADY_S, WREADY_S});
        end
      end
      tick();
    end
    WVALID_S = 1'b0; WLAST_S = 1'b0; RREADY_S = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    AWVALID_S = 1'b1; AWID_S = 8'h77; AWLEN_S = 4'd0; BREADY_S = 1'b0;
    tick();
    AWVALID_S = 1'b0;
    WVALID_S = 1'b1; WLAST_S = 1'b1;
    tick();
    WVALID_S = 1'b0; WLAST_S = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({BVALID_S, BID_S, BRESP_S} !== {1'b1, 8'h77, 2'b11}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h, expected %h", i, {BVALID_S, BID_S, BRESP_S}, {1'b1, 8'h77, 2'b11});
      end
      tick();
    end
    BREADY_S = 1'b1;
    tick();
    BREADY_S = 1'b0;
    checks++;
    if ({BVALID_S, AWREADY_S, proto_err_o} !== 3'b011) begin
      errors++;
      $display("FAIL bp_release: got %b, expected 011", {BVALID_S, AWREADY_S, proto_err_o});
    end
    ARVALID_S = 1'b1; ARID_S = 8'h44; ARLEN_S = 4'd3; RREADY_S = 1'b1;
    tick();
    ARVALID_S = 1'b0;
    tick();
    tick();
    checks++;
    if ({RVALID_S, RID_S, RLAST_S} !== {1'b1, 8'h44, 1'b0}) begin
      errors++;
      $display("FAIL rst_midread_pre: got %h, expected %h", {RVALID_S, RID_S, RLAST_S}, {1'b1, 8'h44, 1'b0});
    end
    ARESETn = 1'b0;
    tick();
    checks++;
    if ({RVALID_S, BVALID_S, WREADY_S, AWREADY_S, ARREADY_S, proto_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL rst_midread: got %b, expected 000000",
               {RVALID_S, BVALID_S, WREADY_S, AWREADY_S, ARREADY_S, proto_err_o});
    end
    checks++;
    if ({RID_S, RLAST_S, RRESP_S} !== 11'h0) begin
      errors++;
      $display("FAIL rst_midread_payload: got %h, expected 0", {RID_S, RLAST_S, RRESP_S});
    end
    ARESETn = 1'b1; RREADY_S = 1'b0;
    tick();
    checks++;
    if ({AWREADY_S, ARREADY_S, RVALID_S, BVALID_S, proto_err_o} !== 5'b11000) begin
      errors++;
      $display("FAIL rst_recover: got %b, expected 11000",
               {AWREADY_S, ARREADY_S, RVALID_S, BVALID_S, proto_err_o});
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWVALID_S = 1'b0;
    WDATA_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0; BREADY_S = 1'b0;
    ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARVALID_S = 1'b0; RREADY_S = 1'b0;
    #1;
    test_reset();
    test_single_write();
    test_read_stall();
    test_wlast_mismatch();
    test_concurrent();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_axi_default_slave

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- AXI responder for the default-slave port of the interconnect. The interconnect routes every access whose address maps to no real slave here.
- Completes every write and read burst it receives with a DECERR response, so no master ever hangs on an unmapped address.
- Independent write and read engines, one outstanding transaction per direction. Write data and read data are never stored.
- Also reports a sticky protocol-error flag when a write's WLAST disagrees with its AWLEN.

Parameters:
ID_BITS, 8, width of AWID/ARID/BID/RID (slave-side ID)
ADDR_BITS, 32, address width
DATA_BITS, 32, data width
LEN_BITS, 4, burst length field width (beats = LEN+1)

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
AWID_S  in  ID_BITS  write address ID
AWADDR_S  in  ADDR_BITS  write address (ignored)
AWLEN_S  in  LEN_BITS  write burst length
AWVALID_S  in  1  write address valid
AWREADY_S  out  1  write address ready
WDATA_S  in  DATA_BITS  write data (discarded)
WLAST_S  in  1  last write beat
WVALID_S  in  1  write data valid
WREADY_S  out  1  write data ready
BID_S  out  ID_BITS  write response ID
BRESP_S  out  2  write response
BVALID_S  out  1  write response valid
BREADY_S  in  1  write response ready
ARID_S  in  ID_BITS  read address ID
ARADDR_S  in  ADDR_BITS  read address (ignored)
ARLEN_S  in  LEN_BITS  read burst length
ARVALID_S  in  1  read address valid
ARREADY_S  out  1  read address ready
RID_S  out  ID_BITS  read ID
RDATA_S  out  DATA_BITS  read data, always 0
RRESP_S  out  2  read response
RLAST_S  out  1  last read beat
RVALID_S  out  1  read data valid
RREADY_S  in  1  read data ready
proto_err_o  out  1  sticky: WLAST mismatch seen

Behaviour:
- Clocking and reset: one clock, ACLK. Reset ARESETn is synchronous, active-low, sampled on the rising ACLK edge.
- Outputs while in reset: both FSMs idle, all VALID outputs 0, ID/len/count registers 0, proto_err_o 0, AWREADY_S=ARREADY_S=0.
- After the first cycle with ARESETn=1: AWREADY_S=1 and ARREADY_S=1 (idle state).
- Reset mid-burst: abandons the burst immediately, no response is issued.
- Write FSM states W_IDLE, W_DATA, W_RESP; all outputs decoded from the registered state.
  - W_IDLE: AWREADY_S=1.
    - On AWVALID_S, latch AWID_S and AWLEN_S, clear the beat counter, go to W_DATA.
  - W_DATA: WREADY_S=1; count beats on each WVALID_S handshake.
    - The burst ends on the handshake where count==latched len; go to W_RESP.
    - If WLAST_S=1 on a non-final beat, or WLAST_S=0 on the final beat, set proto_err_o. Termination still follows the count.
  - W_RESP: BVALID_S=1, BRESP_S=2'b11 (DECERR), BID_S=latched ID. BVALID_S holds until BREADY_S, then go to W_IDLE.
  - Write timing: AW handshake at cycle t gives WREADY_S=1 from t+1. Final W handshake at cycle u gives BVALID_S=1 at u+1.
  - W beats presented before AW are not accepted (WREADY_S=0 in W_IDLE).
- Read FSM states R_IDLE, R_DATA.
  - R_IDLE: ARREADY_S=1.
    - On ARVALID_S, latch ARID_S and ARLEN_S, clear the beat counter, go to R_DATA.
  - R_DATA: RVALID_S=1, RDATA_S=0, RRESP_S=2'b11, RID_S=latched ID, RLAST_S=(count==latched len).
    - On each RREADY_S handshake, increment the count.
    - On the handshake with RLAST_S=1, go to R_IDLE.
  - Read timing: AR handshake at t gives first RVALID_S at t+1; one beat per cycle under continuous RREADY_S.
  - RVALID_S and the R payload are held stable while RREADY_S=0.
  - Outside R_DATA, RID_S/RDATA_S/RRESP_S/RLAST_S are 0.
- Independence and limits:
  - The write and read engines share no state; simultaneous AW and AR handshakes in the same cycle are both accepted.
  - Beat counters are LEN_BITS wide. The maximum length 15 (16 beats) completes without wrap.
- proto_err_o clears only on reset.

Decomposition:
- Shared AXI package: response encodings (OKAY=2'b00, DECERR=2'b11) plus the write-state and read-state enums.
- Width defaults come from the existing AXI defines.
- One natural sub-module, axi_burst_counter: a beat counter with clear, increment and a last flag (count==len). Instantiated once for W and once for R.

Test Plan:
- Single-beat write: AWID=8'h5A, AWLEN=0, then W with WLAST=1 and BREADY=1 → BVALID one cycle after the W handshake, BID=8'h5A, BRESP=2'b11, proto_err_o=0.
- 4-beat read: ARID=8'h21, ARLEN=3, RREADY toggling 1,0,1,1,0,1 → exactly 4 beats, RDATA=0, RRESP=2'b11, RLAST only on beat 4, payload stable during stalls, ARREADY=1 one cycle after the final beat.
- WLAST mismatch: AWLEN=2, WLAST=1 on beat 1 → three W beats still accepted, BRESP=2'b11, proto_err_o=1 from the cycle after beat 1 and staying 1.
- Concurrent traffic: AW (ID 8'h01, LEN 1) and AR (ID 8'h02, LEN 15) in the same cycle → both accepted; 16 R beats carry RID=8'h02; B carries BID=8'h01; neither stream blocks the other.
- Backpressure plus reset: hold BREADY=0 for 5 cycles → BVALID held with constant BID; then drive ARESETn=0 mid-read (beat 2 of 4) → next cycle all VALIDs 0 and proto_err_o 0; after release, AWREADY=ARREADY=1.
